// File: rtl/vending_pkg.sv
// Shared encodings for the vending core: request modes, error codes and FSM states.
package vending_pkg;

    // Request modes
    localparam logic [1:0] MODE_NOP       = 2'd0;
    localparam logic [1:0] MODE_SELL      = 2'd1;
    localparam logic [1:0] MODE_RESTOCK   = 2'd2;
    localparam logic [1:0] MODE_SET_PRICE = 2'd3;

    // Error codes; NO_STOCK also reports a restock overflow
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_ARG  = 2'd1;
    localparam logic [1:0] ERR_NO_STOCK = 2'd2;
    localparam logic [1:0] ERR_NO_FUNDS = 2'd3;

    // FSM state type and legacy-compatible encodings
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CHECK  = 2'd1;
    localparam state_t ST_COMMIT = 2'd2;

endpackage

// File: rtl/stock_bank.sv
// Per-type stock and price registers with a combinational read port and a
// single write port that updates both fields of one entry.
module stock_bank
    import vending_pkg::*;
#(
    parameter int unsigned N_TYPES       = 8,
    parameter int unsigned STOCK_W       = 4,
    parameter int unsigned MONEY_W       = 7,
    parameter int unsigned INIT_STOCK    = 5,
    parameter int unsigned DEFAULT_PRICE = 5,
    parameter int unsigned IDX_W         = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [STOCK_W-1:0] rd_stock,
    output logic [MONEY_W-1:0] rd_price,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [STOCK_W-1:0] wr_stock,
    input  logic [MONEY_W-1:0] wr_price
);

    logic [STOCK_W-1:0] stock_q [N_TYPES];
    logic [MONEY_W-1:0] price_q [N_TYPES];

    // Read port; out-of-range indices read as zero
    always_comb begin
        rd_stock = '0;
        rd_price = '0;
        if (32'(rd_idx) < N_TYPES) begin
            rd_stock = stock_q[rd_idx];
            rd_price = price_q[rd_idx];
        end
    end

    // Register array: reset to initial values, single guarded write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_TYPES; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
                price_q[i] <= MONEY_W'(DEFAULT_PRICE);
            end
        end else if (wr_en && (32'(wr_idx) < N_TYPES)) begin
            stock_q[wr_idx] <= wr_stock;
            price_q[wr_idx] <= wr_price;
        end
    end

endmodule

// File: rtl/vending_core_param.sv
// Vending machine core: accepts a SELL / RESTOCK / SET_PRICE / NOP request,
// validates it against the stock bank, and commits it two states later.
module vending_core_param
    import vending_pkg::*;
#(
    parameter int unsigned N_TYPES       = 8,
    parameter int unsigned STOCK_W       = 4,
    parameter int unsigned MONEY_W       = 7,
    parameter int unsigned INIT_STOCK    = 5,
    parameter int unsigned DEFAULT_PRICE = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 mode,
    input  logic                       req,
    input  logic [$clog2(N_TYPES)-1:0] supply_type,
    input  logic [STOCK_W-1:0]         amount,
    input  logic [MONEY_W-1:0]         money,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [MONEY_W-1:0]         change
);

    localparam int unsigned IDX_W  = $clog2(N_TYPES);
    localparam int unsigned COST_W = MONEY_W + STOCK_W;

    state_t             state;
    logic [1:0]         mode_q;
    logic [IDX_W-1:0]   type_q;
    logic [STOCK_W-1:0] amount_q;
    logic [MONEY_W-1:0] money_q;

    logic [STOCK_W-1:0] rd_stock;
    logic [MONEY_W-1:0] rd_price;
    logic [STOCK_W-1:0] new_stock_q;
    logic [MONEY_W-1:0] new_price_q;
    logic               wr_en;

    logic               type_ok;
    logic [COST_W-1:0]  cost;
    logic [STOCK_W:0]   restock_sum;
    logic [1:0]         chk_code;
    logic [MONEY_W-1:0] chk_change;
    logic [STOCK_W-1:0] chk_stock;
    logic [MONEY_W-1:0] chk_price;

    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_COMMIT);
    assign wr_en = (state == ST_COMMIT) && !error && (mode_q != MODE_NOP);

    stock_bank #(
        .N_TYPES       (N_TYPES),
        .STOCK_W       (STOCK_W),
        .MONEY_W       (MONEY_W),
        .INIT_STOCK    (INIT_STOCK),
        .DEFAULT_PRICE (DEFAULT_PRICE),
        .IDX_W         (IDX_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (type_q),
        .rd_stock (rd_stock),
        .rd_price (rd_price),
        .wr_en    (wr_en),
        .wr_idx   (type_q),
        .wr_stock (new_stock_q),
        .wr_price (new_price_q)
    );

    // Validate the registered request against the bank and compute the outcome
    always_comb begin
        type_ok     = (32'(type_q) < N_TYPES);
        cost        = COST_W'(rd_price) * COST_W'(amount_q);
        restock_sum = {1'b0, rd_stock} + {1'b0, amount_q};
        chk_code    = ERR_NONE;
        chk_change  = '0;
        chk_stock   = rd_stock;
        chk_price   = rd_price;
        case (mode_q)
            MODE_SELL: begin
                if (!type_ok || (amount_q == '0)) begin
                    chk_code = ERR_BAD_ARG;
                end else if (amount_q > rd_stock) begin
                    chk_code = ERR_NO_STOCK;
                end else if (cost > COST_W'(money_q)) begin
                    chk_code = ERR_NO_FUNDS;
                end else begin
                    chk_stock  = rd_stock - amount_q;
                    chk_change = money_q - cost[MONEY_W-1:0];
                end
            end
            MODE_RESTOCK: begin
                if (!type_ok) begin
                    chk_code = ERR_BAD_ARG;
                end else if (restock_sum[STOCK_W]) begin
                    chk_code = ERR_NO_STOCK;
                end else begin
                    chk_stock = restock_sum[STOCK_W-1:0];
                end
            end
            MODE_SET_PRICE: begin
                if (!type_ok) begin
                    chk_code = ERR_BAD_ARG;
                end else begin
                    chk_price = money_q;
                end
            end
            default: begin
            end
        endcase
    end

    // FSM: latch operands on accept, register the verdict in CHECK, pulse done in COMMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_NOP;
            type_q      <= '0;
            amount_q    <= '0;
            money_q     <= '0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            change      <= '0;
            new_stock_q <= '0;
            new_price_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state    <= ST_CHECK;
                        mode_q   <= mode;
                        type_q   <= supply_type;
                        amount_q <= amount;
                        money_q  <= money;
                        error    <= 1'b0;
                        err_code <= ERR_NONE;
                        change   <= '0;
                    end
                end
                ST_CHECK: begin
                    state       <= ST_COMMIT;
                    error       <= (chk_code != ERR_NONE);
                    err_code    <= chk_code;
                    change      <= chk_change;
                    new_stock_q <= chk_stock;
                    new_price_q <= chk_price;
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vending_core_param.md
VENDING_CORE_PARAM -- requirements
Module: vending_core_param

Interface
REQ-001 SHALL have parameter N_TYPES, default 8: number of supply types.
REQ-002 SHALL have parameter STOCK_W, default 4: stock and amount width.
REQ-003 SHALL have parameter MONEY_W, default 7: money, price and change width.
REQ-004 SHALL have parameter INIT_STOCK, default 5: per-type stock after reset.
REQ-005 SHALL have parameter DEFAULT_PRICE, default 5: per-type price after reset.
REQ-006 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port mode, input, 2: 0 NOP, 1 SELL, 2 RESTOCK, 3 SET_PRICE.
REQ-009 SHALL have port req, input, 1: request strobe, sampled only when busy=0.
REQ-010 SHALL have port supply_type, input, clog2(N_TYPES): target type.
REQ-011 SHALL have port amount, input, STOCK_W: units to sell or add.
REQ-012 SHALL have port money, input, MONEY_W: customer money (SELL) or new price (SET_PRICE).
REQ-013 SHALL have port busy, output, 1: high from request acceptance until done.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port error, output, 1: request rejected; valid with done, held until next accept.
REQ-016 SHALL have port err_code, output, 2: 0 none, 1 BAD_ARG, 2 NO_STOCK/OVERFLOW, 3 NO_FUNDS.
REQ-017 SHALL have port change, output, MONEY_W: change returned; valid with done, held until next accept.

Function
REQ-018 SHALL use FSM states IDLE, CHECK, COMMIT; req and all operands are registered on acceptance in IDLE.
REQ-019 SHALL transition IDLE->CHECK on req; CHECK->COMMIT always; COMMIT->IDLE with done=1 in COMMIT, giving a done pulse exactly 2 cycles after the accepting edge.
REQ-020 SHALL ignore req while busy=1; inputs changing mid-operation SHALL have no effect.
REQ-021 SHALL, for SELL, compute cost = price[type]*amount at MONEY_W+STOCK_W bits without truncation.
REQ-022 SHALL check SELL in priority order: type>=N_TYPES or amount=0 -> BAD_ARG; amount>stock -> NO_STOCK; cost>money -> NO_FUNDS.
REQ-023 SHALL, on SELL success, decrement stock[type] by amount and set change=money-cost; on any error, change=0 and no state update.
REQ-024 SHALL, for RESTOCK, reject with OVERFLOW when stock+amount > 2^STOCK_W-1 (no saturation, no partial add); otherwise add; change=0.
REQ-025 SHALL, for SET_PRICE, write price[type]=money; price 0 is legal (free item); change=0.
REQ-026 SHALL treat NOP as a successful operation: done pulses, error=0, change=0, no state update.
REQ-027 SHALL apply the BAD_ARG type check to RESTOCK and SET_PRICE.

Reset
REQ-028 SHALL, on rst, immediately force state IDLE, busy=0, done=0, error=0, err_code=0, change=0.
REQ-029 SHALL, on rst, set every stock to INIT_STOCK and every price to DEFAULT_PRICE.
REQ-030 SHALL abandon an in-flight request on rst mid-operation, producing no done pulse and no stock or price update.

Structure
REQ-031 SHALL take mode encodings, err_code encodings, and the FSM state type from a shared package vending_pkg.
REQ-032 SHALL place the per-type stock and price register arrays, with read ports and a single write port, in sub-module stock_bank.

Verification (default parameters)
REQ-033 SHALL cover: SELL type 3, amount 1, money 20 -> done 2 cycles later, error 0, change 15, stock[3]=4.
REQ-034 SHALL cover: SELL type 0, amount 3, money 25 -> change 10, stock[0]=2; then the same request -> error, err_code 2, stock[0] stays 2.
REQ-035 SHALL cover: RESTOCK type 2, amount 10 -> stock 15; then RESTOCK amount 1 -> err_code 2, stock stays 15.
REQ-036 SHALL cover: SET_PRICE type 1, money 40; SELL type 1, amount 1, money 25 -> err_code 3, change 0, stock[1]=5.
REQ-037 SHALL cover: req with type 3, amount 1, money 20, then rst during CHECK -> no done, all outputs 0, stock[3]=5.
REQ-038 SHALL cover: second req while busy -> ignored (one done only); SELL with amount 0 -> err_code 1.
